// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: Mem2Reg select codes, hazard FSM states, widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [1:0] MEM2REG_ALU = 2'b00;
  localparam logic [1:0] MEM2REG_MEM = 2'b01;
  localparam logic [1:0] MEM2REG_PC  = 2'b10;

  typedef enum logic {
    HZ_RUN,
    HZ_STALL
  } hz_state_t;

endpackage

// File: rtl/hazard_redirect_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/redirect controller.
// Latency: none (wires only).
// Backpressure: none; the controller answers through the enable/flush outputs.
//   master : pipeline side, drives the EX/ID fields and reads the controls
//   slave  : controller side, reads the EX/ID fields and drives the controls
interface hazard_redirect_ctrl_if;
  import pipe_pkg::*;

  logic                  EXBeq_In;
  logic                  EXBne_In;
  logic [DATA_W-1:0]     EXRegData1_In;
  logic [DATA_W-1:0]     EXRegData2_In;
  logic [DATA_W-1:0]     EXPCAddr_In;
  logic [15:0]           EXImm_In;
  logic                  EXRegWriteEN_In;
  logic [1:0]            EXMem2RegSEL_In;
  logic [REG_ADDR_W-1:0] EXRTAddr_In;
  logic [REG_ADDR_W-1:0] IDRSAddr_In;
  logic [REG_ADDR_W-1:0] IDRTAddr_In;
  logic                  IDUsesRT_In;

  logic                  PCWriteEN_Out;
  logic                  IFIDWriteEN_Out;
  logic                  IFIDFlush_Out;
  logic                  IDEXFlush_Out;
  logic                  PCRedirectEN_Out;
  logic [DATA_W-1:0]     PCRedirectAddr_Out;
  logic [31:0]           StallCount_Out;
  logic [31:0]           FlushCount_Out;

  modport master (
    output EXBeq_In, EXBne_In, EXRegData1_In, EXRegData2_In, EXPCAddr_In,
           EXImm_In, EXRegWriteEN_In, EXMem2RegSEL_In, EXRTAddr_In,
           IDRSAddr_In, IDRTAddr_In, IDUsesRT_In,
    input  PCWriteEN_Out, IFIDWriteEN_Out, IFIDFlush_Out, IDEXFlush_Out,
           PCRedirectEN_Out, PCRedirectAddr_Out, StallCount_Out, FlushCount_Out
  );

  modport slave (
    input  EXBeq_In, EXBne_In, EXRegData1_In, EXRegData2_In, EXPCAddr_In,
           EXImm_In, EXRegWriteEN_In, EXMem2RegSEL_In, EXRTAddr_In,
           IDRSAddr_In, IDRTAddr_In, IDUsesRT_In,
    output PCWriteEN_Out, IFIDWriteEN_Out, IFIDFlush_Out, IDEXFlush_Out,
           PCRedirectEN_Out, PCRedirectAddr_Out, StallCount_Out, FlushCount_Out
  );

endinterface

// File: rtl/hazard_redirect_ctrl_branch_resolve.sv
// Module branch_resolve: beq/bne outcome and branch target from EX operands.
// Latency: purely combinational.
// Backpressure: none.
//   in : beq, bne, d1, d2, pc4 (PC+4), imm (raw 16-bit immediate)
//   out: taken, target = pc4 + sign_extend(imm) << 2, wrapping mod 2^32
module branch_resolve
  import pipe_pkg::*;
(
  input  logic              beq,
  input  logic              bne,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] pc4,
  input  logic [15:0]       imm,
  output logic              taken,
  output logic [DATA_W-1:0] target
);

  logic              eq;
  logic [DATA_W-1:0] offset;

  assign eq     = (d1 == d2);
  // beq and bne both set is not legal, but simply OR-ing the terms is harmless.
  assign taken  = (beq & eq) | (bne & ~eq);
  assign offset = {{14{imm[15]}}, imm, 2'b00};
  assign target = pc4 + offset;

endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Branch redirect and load-use stall control for the 5-stage pipeline.
// Latency: controls are combinational from state+inputs; redirect lands at next edge.
// Backpressure: load-use freezes PC and IF/ID for STALL_CYCLES cycles (bubbles in ID/EX).
//   ports: CLOCK, RESET (async, active-high), hz (hazard_redirect_ctrl_if.slave)
//   macro: HAZARD_STATS_EN adds saturating stall/flush statistics counters;
//          without it StallCount_Out/FlushCount_Out are tied to 0.
module hazard_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CYCLES = 1  // legal range 1..7
)(
  input  logic                 CLOCK,
  input  logic                 RESET,
  hazard_redirect_ctrl_if.slave hz
);

  localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

  hz_state_t         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              taken;
  logic [DATA_W-1:0] target;
  logic              load_use;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_flush;
  logic              redirect;

  branch_resolve u_branch_resolve (
    .beq    (hz.EXBeq_In),
    .bne    (hz.EXBne_In),
    .d1     (hz.EXRegData1_In),
    .d2     (hz.EXRegData2_In),
    .pc4    (hz.EXPCAddr_In),
    .imm    (hz.EXImm_In),
    .taken  (taken),
    .target (target)
  );

  // A load writing $0 never produces a usable value, so it can't cause a hazard.
  assign load_use = hz.EXRegWriteEN_In
                  & (hz.EXMem2RegSEL_In == MEM2REG_MEM)
                  & (hz.EXRTAddr_In != '0)
                  & ((hz.EXRTAddr_In == hz.IDRSAddr_In)
                     | (hz.IDUsesRT_In & (hz.EXRTAddr_In == hz.IDRTAddr_In)));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    redirect   = 1'b0;

    case (state_q)
      HZ_RUN: begin
        // The ID instruction behind a taken branch is wrong-path, so a
        // simultaneous load-use match is irrelevant and the branch wins.
        if (taken) begin
          redirect   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = HZ_STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end

      HZ_STALL: begin
        // EX holds a bubble here, so branch/load-use inputs are not looked at.
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = HZ_RUN;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end
    endcase

    // While held in reset the pipeline is frozen and flushed.
    if (RESET) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      redirect   = 1'b0;
    end
  end

  assign hz.PCWriteEN_Out      = pc_we;
  assign hz.IFIDWriteEN_Out    = ifid_we;
  assign hz.IFIDFlush_Out      = ifid_flush;
  assign hz.IDEXFlush_Out      = idex_flush;
  assign hz.PCRedirectEN_Out   = redirect;
  assign hz.PCRedirectAddr_Out = RESET ? '0 : target;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Reset holds both counters, so reset-time PC freezes are never counted.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz.StallCount_Out = stall_cnt_q;
  assign hz.FlushCount_Out = flush_cnt_q;
`else
  assign hz.StallCount_Out = '0;
  assign hz.FlushCount_Out = '0;
`endif

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Bench for hazard_redirect_ctrl: three instances (STALL_CYCLES 1, 2, 3) share stimulus.
// Latency: outputs sampled 1 time unit after inputs change, mid-cycle.
// Backpressure: not applicable.
module tb_hazard_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        beq, bne, wen, uses_rt;
  logic [31:0] d1, d2, pc;
  logic [15:0] imm;
  logic [1:0]  sel;
  logic [4:0]  ex_rt, id_rs, id_rt;

  logic [2:0]  pcw, ifidw, ififl, idexfl, redir;
  logic [31:0] raddr [3];
  logic [31:0] scnt  [3];
  logic [31:0] fcnt  [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance g uses STALL_CYCLES = g+1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_redirect_ctrl_if hif ();
    assign hif.EXBeq_In        = beq;
    assign hif.EXBne_In        = bne;
    assign hif.EXRegData1_In   = d1;
    assign hif.EXRegData2_In   = d2;
    assign hif.EXPCAddr_In     = pc;
    assign hif.EXImm_In        = imm;
    assign hif.EXRegWriteEN_In = wen;
    assign hif.EXMem2RegSEL_In = sel;
    assign hif.EXRTAddr_In     = ex_rt;
    assign hif.IDRSAddr_In     = id_rs;
    assign hif.IDRTAddr_In     = id_rt;
    assign hif.IDUsesRT_In     = uses_rt;

    hazard_redirect_ctrl #(.STALL_CYCLES(g + 1)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .hz    (hif)
    );

    assign pcw[g]    = hif.PCWriteEN_Out;
    assign ifidw[g]  = hif.IFIDWriteEN_Out;
    assign ififl[g]  = hif.IFIDFlush_Out;
    assign idexfl[g] = hif.IDEXFlush_Out;
    assign redir[g]  = hif.PCRedirectEN_Out;
    assign raddr[g]  = hif.PCRedirectAddr_Out;
    assign scnt[g]   = hif.StallCount_Out;
    assign fcnt[g]   = hif.FlushCount_Out;
  end

  task automatic clear_inputs();
    beq = 0; bne = 0; wen = 0; uses_rt = 0;
    d1 = 0; d2 = 0; pc = 0; imm = 0; sel = 2'b00;
    ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rt, input logic [4:0] rs,
                              input logic [4:0] rt_id, input logic use_rt);
    wen = 1; sel = 2'b01; ex_rt = rt; id_rs = rs; id_rt = rt_id; uses_rt = use_rt;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    pc = 32'h100; imm = 16'h0004;
    #3;
    checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL reset_pcw got %b exp 0", pcw[0]); end
    checks++; if (ifidw[0] !== 1'b0) begin errors++; $display("FAIL reset_ifidw got %b exp 0", ifidw[0]); end
    checks++; if (ififl[0] !== 1'b1 || idexfl[0] !== 1'b1) begin errors++; $display("FAIL reset_flush got %b%b exp 11", ififl[0], idexfl[0]); end
    checks++; if (redir[0] !== 1'b0 || raddr[0] !== 32'h0) begin errors++; $display("FAIL reset_redirect got %b %h exp 0 00000000", redir[0], raddr[0]); end
    checks++; if (scnt[1] !== 32'h0 || fcnt[1] !== 32'h0) begin errors++; $display("FAIL reset_counts got %h %h exp 0 0", scnt[1], fcnt[1]); end
    @(negedge clk);
    rst = 0;
    clear_inputs();
    next_cyc();
    checks++; if (pcw !== 3'b111 || idexfl !== 3'b000 || ififl !== 3'b000) begin errors++; $display("FAIL post_reset_idle got %b %b %b exp 111 000 000", pcw, idexfl, ififl); end
  endtask

  task automatic test_branch();
    beq = 1; d1 = 32'h5; d2 = 32'h5; pc = 32'h100; imm = 16'h0004;
    #1;
    checks++; if (redir[0] !== 1'b1 || raddr[0] !== 32'h110) begin errors++; $display("FAIL beq_taken got %b %h exp 1 00000110", redir[0], raddr[0]); end
    checks++; if (ififl[0] !== 1'b1 || idexfl[0] !== 1'b1 || pcw[0] !== 1'b1) begin errors++; $display("FAIL beq_flush got %b%b%b exp 111", ififl[0], idexfl[0], pcw[0]); end
    beq = 0; bne = 1; d1 = 32'h1; d2 = 32'h1; imm = 16'hFFFF;
    #1;
    checks++; if (redir[0] !== 1'b0 || ififl[0] !== 1'b0 || idexfl[0] !== 1'b0 || pcw[0] !== 1'b1) begin errors++; $display("FAIL bne_not_taken got %b%b%b%b exp 0001", redir[0], ififl[0], idexfl[0], pcw[0]); end
    d2 = 32'h2;
    #1;
    checks++; if (redir[0] !== 1'b1 || raddr[0] !== 32'h0FC) begin errors++; $display("FAIL bne_taken got %b %h exp 1 000000fc", redir[0], raddr[0]); end
    beq = 1;
    #1;
    checks++; if (redir[0] !== 1'b1) begin errors++; $display("FAIL beq_bne_both got %b exp 1", redir[0]); end
    clear_inputs();
    next_cyc();
  endtask

  task automatic test_load_use();
    set_load_use(5'd8, 5'd8, 5'd0, 1'b0);
    #1;
    checks++; if (pcw[0] !== 1'b0 || ifidw[0] !== 1'b0 || idexfl[0] !== 1'b1 || ififl[0] !== 1'b0) begin errors++; $display("FAIL lu_rs_hit got %b%b%b%b exp 0010", pcw[0], ifidw[0], idexfl[0], ififl[0]); end
    next_cyc();
    clear_inputs();
    #1;
    checks++; if (pcw[0] !== 1'b1 || idexfl[0] !== 1'b0) begin errors++; $display("FAIL lu_one_bubble got %b%b exp 10", pcw[0], idexfl[0]); end
    set_load_use(5'd8, 5'd0, 5'd8, 1'b0);
    #1;
    checks++; if (pcw[0] !== 1'b1 || idexfl[0] !== 1'b0) begin errors++; $display("FAIL lu_rt_unused got %b%b exp 10", pcw[0], idexfl[0]); end
    uses_rt = 1;
    #1;
    checks++; if (pcw[0] !== 1'b0 || idexfl[0] !== 1'b1) begin errors++; $display("FAIL lu_rt_used got %b%b exp 01", pcw[0], idexfl[0]); end
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL lu_zero_reg got %b exp 1", pcw[0]); end
    set_load_use(5'd8, 5'd8, 5'd0, 1'b0);
    sel = 2'b00;
    #1;
    checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL lu_alu_sel got %b exp 1", pcw[0]); end
    clear_inputs();
    repeat (4) next_cyc();
  endtask

  task automatic test_stall3();
    set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
    #1;
    checks++; if (pcw[2] !== 1'b0 || idexfl[2] !== 1'b1) begin errors++; $display("FAIL s3_c1 got %b%b exp 01", pcw[2], idexfl[2]); end
    next_cyc();
    clear_inputs();
    beq = 1; d1 = 32'h7; d2 = 32'h7; pc = 32'h200;
    #1;
    checks++; if (pcw[2] !== 1'b0 || idexfl[2] !== 1'b1 || redir[2] !== 1'b0) begin errors++; $display("FAIL s3_c2_ignore_branch got %b%b%b exp 010", pcw[2], idexfl[2], redir[2]); end
    next_cyc();
    clear_inputs();
    #1;
    checks++; if (pcw[2] !== 1'b0 || ifidw[2] !== 1'b0) begin errors++; $display("FAIL s3_c3 got %b%b exp 00", pcw[2], ifidw[2]); end
    next_cyc();
    checks++; if (pcw[2] !== 1'b1 || idexfl[2] !== 1'b0) begin errors++; $display("FAIL s3_back_to_run got %b%b exp 10", pcw[2], idexfl[2]); end
  endtask

  task automatic test_reset_abort();
    set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
    next_cyc();
    clear_inputs();
    pc = 32'h100;
    #1;
    checks++; if (pcw[2] !== 1'b0) begin errors++; $display("FAIL abort_pre got %b exp 0", pcw[2]); end
    rst = 1;
    #1;
    checks++; if (pcw[2] !== 1'b0 || ififl[2] !== 1'b1 || idexfl[2] !== 1'b1 || raddr[2] !== 32'h0) begin errors++; $display("FAIL abort_rst_vals got %b%b%b %h exp 011 00000000", pcw[2], ififl[2], idexfl[2], raddr[2]); end
    @(negedge clk);
    rst = 0;
    clear_inputs();
    next_cyc();
    checks++; if (pcw[2] !== 1'b1 || idexfl[2] !== 1'b0) begin errors++; $display("FAIL abort_run got %b%b exp 10", pcw[2], idexfl[2]); end
  endtask

  task automatic test_priority();
    beq = 1; d1 = 32'h3; d2 = 32'h3; pc = 32'h40; imm = 16'h0002;
    set_load_use(5'd4, 5'd4, 5'd0, 1'b0);
    #1;
    checks++; if (redir[2] !== 1'b1 || pcw[2] !== 1'b1 || ififl[2] !== 1'b1 || idexfl[2] !== 1'b1 || raddr[2] !== 32'h48) begin errors++; $display("FAIL prio_same_cycle got %b%b%b%b %h exp 1111 00000048", redir[2], pcw[2], ififl[2], idexfl[2], raddr[2]); end
    next_cyc();
    clear_inputs();
    #1;
    checks++; if (pcw[2] !== 1'b1 || idexfl[2] !== 1'b0) begin errors++; $display("FAIL prio_no_stall got %b%b exp 10", pcw[2], idexfl[2]); end
  endtask

  task automatic test_stats();
    rst = 1;
    #2;
    rst = 0;
    clear_inputs();
    next_cyc();
    for (int k = 0; k < 2; k++) begin
      set_load_use(5'd5, 5'd5, 5'd0, 1'b0);
      next_cyc();
      clear_inputs();
      next_cyc();
    end
    beq = 1;
    next_cyc();
    clear_inputs();
    #1;
`ifdef HAZARD_STATS_EN
    checks++; if (scnt[1] !== 32'd4 || fcnt[1] !== 32'd1) begin errors++; $display("FAIL stats_counts got %0d %0d exp 4 1", scnt[1], fcnt[1]); end
    force g_dut[1].dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release g_dut[1].dut.stall_cnt_q;
    set_load_use(5'd5, 5'd5, 5'd0, 1'b0);
    next_cyc();
    clear_inputs();
    next_cyc();
    checks++; if (scnt[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_saturate got %h exp ffffffff", scnt[1]); end
`else
    checks++; if (scnt[1] !== 32'd0 || fcnt[1] !== 32'd0 || scnt[2] !== 32'd0) begin errors++; $display("FAIL stats_tied_off got %h %h %h exp 0 0 0", scnt[1], fcnt[1], scnt[2]); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch();
    test_load_use();
    test_stall3();
    test_reset_abort();
    test_priority();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_redirect_ctrl.md
Name: hazard_redirect_ctrl

Overview:
- Backward-facing control block for the 5-stage MIPS pipeline.
- Reads the EX-side outputs of the ID/EX pipeline register and the ID-stage source addresses.
- Resolves beq/bne in EX and sends a PC redirect plus flushes back to IF/ID and ID/EX.
- Detects load-use RAW hazards and freezes PC and IF/ID for a parameterised number of bubble cycles using a small FSM.

Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- CLOCK  input  1  pipeline clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EXBeq_In  input  1  Beq from ID/EX.
- EXBne_In  input  1  Bne from ID/EX.
- EXRegData1_In  input  32  rs operand in EX.
- EXRegData2_In  input  32  rt operand in EX.
- EXPCAddr_In  input  32  PC+4 of the instruction in EX.
- EXImm_In  input  16  raw immediate in EX.
- EXRegWriteEN_In  input  1  RegWriteEN in EX.
- EXMem2RegSEL_In  input  2  Mem2RegSEL in EX.
- EXRTAddr_In  input  5  load destination (rt) in EX.
- IDRSAddr_In  input  5  rs of the instruction in ID.
- IDRTAddr_In  input  5  rt of the instruction in ID.
- IDUsesRT_In  input  1  ID instruction reads rt as a source.
- PCWriteEN_Out  output  1  PC register update enable.
- IFIDWriteEN_Out  output  1  IF/ID register update enable.
- IFIDFlush_Out  output  1  load nop into IF/ID.
- IDEXFlush_Out  output  1  load all-zero bubble into ID/EX.
- PCRedirectEN_Out  output  1  PC takes PCRedirectAddr_Out.
- PCRedirectAddr_Out  output  32  branch target.
- StallCount_Out  output  32  stall statistics (see Optional Feature).
- FlushCount_Out  output  32  flush statistics (see Optional Feature).

Behaviour:
- Taken = (EXBeq_In & D1==D2) | (EXBne_In & D1!=D2).
- Target = EXPCAddr_In + ({{14{Imm[15]}},Imm,2'b00}), computed mod 2^32 with wrap-around ignored.
- LoadUse = EXRegWriteEN_In & (EXMem2RegSEL_In==MEM2REG_MEM) & EXRTAddr_In!=0 & (EXRTAddr_In==IDRSAddr_In | (IDUsesRT_In & EXRTAddr_In==IDRTAddr_In)).
- Outputs are combinational from state and inputs; state and counter are registered.
- Defaults: PCWriteEN=1, IFIDWriteEN=1, all flushes 0, PCRedirectEN=0, PCRedirectAddr=Target (don't-care while EN=0).
- State RUN:
  - Taken: PCRedirectEN=1, IFIDFlush=1, IDEXFlush=1; next state RUN. Branch has priority over LoadUse because the ID instruction is wrong-path.
  - Else LoadUse: PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1. If STALL_CYCLES==1, next state RUN; else next state STALL with cnt=STALL_CYCLES-1.
  - Else: defaults.
- State STALL:
  - PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1.
  - EX holds a bubble, so Taken/LoadUse are ignored.
  - cnt decrements each cycle; when cnt==1, next state RUN.
- Latency:
  - Redirect takes effect at the next edge; 2 wrong-path instructions are squashed.
  - A load-use hazard costs exactly STALL_CYCLES bubbles.
- Reset (asynchronous):
  - state=RUN, cnt=0, statistics counters=0.
  - While RESET=1: PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXFlush=1, PCRedirectEN=0, PCRedirectAddr=0.
  - RESET asserted mid-STALL aborts the stall; the first cycle after release is RUN.
- EXRTAddr_In==0 never stalls.
- beq with Bne also set (illegal): Taken is the OR of both terms, with no error.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - StallCount_Out increments on every cycle with PCWriteEN_Out==0 while not in reset.
  - FlushCount_Out increments on every cycle with PCRedirectEN_Out==1.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg:
  - MEM2REG_ALU=2'b00, MEM2REG_MEM=2'b01, MEM2REG_PC=2'b10.
  - hz_state_t enum {HZ_RUN, HZ_STALL}.
  - Width constants REG_ADDR_W=5, DATA_W=32.
- Sub-module branch_resolve: purely combinational Taken and Target, reusable for a future ID-stage branch unit.
- The FSM and statistics counters stay in the top module.

Test Plan:
- beq, D1=D2=32'h5, PC+4=32'h100, Imm=16'h0004 -> same cycle: PCRedirectEN=1, Addr=32'h110, IFIDFlush=IDEXFlush=1.
- bne, D1=1, D2=1, Imm=16'hFFFF -> not taken: all defaults, no flush. Then D2=2 -> Addr=PC+4-4=32'h0FC.
- lw $8 in EX (RegWriteEN=1, SEL=01, RT=8), ID rs=8, STALL_CYCLES=1 -> exactly 1 cycle of PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1. Repeat with rs=0/rt=8/UsesRT=0 -> no stall.
- STALL_CYCLES=3, load-use hit -> 3 consecutive stall cycles (RUN, STALL, STALL), then RUN. Assert RESET in cycle 2 -> stall aborts, RESET-value outputs appear immediately, RUN after release.
- Taken branch and LoadUse match in the same cycle -> redirect and flushes asserted, PCWriteEN=1, no STALL entry.
- HAZARD_STATS_EN defined: 2 load-use (STALL_CYCLES=2) plus 1 taken branch -> StallCount=4, FlushCount=1. Force-preload near max -> saturates at 32'hFFFF_FFFF.
